// File: rtl/dlsc_pcie_s6_inbound_tlp_if.sv
`default_nettype none
// ============================================================================
// Module  : dlsc_pcie_s6_inbound_tlp_if
// Brief   : TLP stream, read/write header, write data and error bundle
// Revision: 1.0  initial release
// ============================================================================
interface dlsc_pcie_s6_inbound_tlp_if #(
    parameter int ADDR = 32
);
    logic               tlp_ready;
    logic               tlp_valid;
    logic [31:0]        tlp_data;
    logic               tlp_last;

    logic               rd_h_ready;
    logic               rd_h_valid;
    logic [ADDR-3:0]    rd_h_addr;
    logic [9:0]         rd_h_len;
    logic [7:0]         rd_h_tag;
    logic [15:0]        rd_h_req_id;
    logic [2:0]         rd_h_tc;
    logic [1:0]         rd_h_attr;
    logic [3:0]         rd_h_be_first;
    logic [3:0]         rd_h_be_last;

    logic               wr_h_ready;
    logic               wr_h_valid;
    logic [ADDR-3:0]    wr_h_addr;
    logic [9:0]         wr_h_len;
    logic [3:0]         wr_h_be_first;
    logic [3:0]         wr_h_be_last;

    logic               wr_d_ready;
    logic               wr_d_valid;
    logic [31:0]        wr_d_data;
    logic               wr_d_last;

    logic               err_unsupported;
    logic               err_malformed;

    // Parser side
    modport slave (
        output tlp_ready,
        input  tlp_valid, tlp_data, tlp_last,
        input  rd_h_ready,
        output rd_h_valid, rd_h_addr, rd_h_len, rd_h_tag, rd_h_req_id,
        output rd_h_tc, rd_h_attr, rd_h_be_first, rd_h_be_last,
        input  wr_h_ready,
        output wr_h_valid, wr_h_addr, wr_h_len, wr_h_be_first, wr_h_be_last,
        input  wr_d_ready,
        output wr_d_valid, wr_d_data, wr_d_last,
        output err_unsupported, err_malformed
    );

    // PCIe core / request handler side
    modport master (
        input  tlp_ready,
        output tlp_valid, tlp_data, tlp_last,
        output rd_h_ready,
        input  rd_h_valid, rd_h_addr, rd_h_len, rd_h_tag, rd_h_req_id,
        input  rd_h_tc, rd_h_attr, rd_h_be_first, rd_h_be_last,
        output wr_h_ready,
        input  wr_h_valid, wr_h_addr, wr_h_len, wr_h_be_first, wr_h_be_last,
        output wr_d_ready,
        input  wr_d_valid, wr_d_data, wr_d_last,
        input  err_unsupported, err_malformed
    );
endinterface
`default_nettype wire

// File: rtl/dlsc_pcie_s6_inbound_tlp.sv
`default_nettype none
// ============================================================================
// Module  : dlsc_pcie_s6_inbound_tlp
// Brief   : Inbound MRd/MWr TLP parser; other TLPs are discarded and flagged
// Revision: 1.0  initial release
// ============================================================================
module dlsc_pcie_s6_inbound_tlp #(
    parameter int ADDR = 32     // 32..64
) (
    input  wire                         clk,
    input  wire                         rst_n,
    dlsc_pcie_s6_inbound_tlp_if.slave   io_tlp
);
    localparam logic [2:0] ST_H0   = 3'd0;
    localparam logic [2:0] ST_H1   = 3'd1;
    localparam logic [2:0] ST_H2   = 3'd2;
    localparam logic [2:0] ST_H3   = 3'd3;
    localparam logic [2:0] ST_DATA = 3'd4;
    localparam logic [2:0] ST_DROP = 3'd5;

    // Upper-address-dword bits that lie beyond the local address space
    localparam logic [31:0] c_HI_MASK = ~((32'h1 << (ADDR - 32)) - 32'h1);

    logic [2:0]         r_st;
    logic [2:0]         w_st_nxt;

    logic [1:0]         r_fmt;
    logic [2:0]         r_tc;
    logic               r_td;
    logic [1:0]         r_attr;
    logic [9:0]         r_len;
    logic [15:0]        r_req_id;
    logic [7:0]         r_tag;
    logic [3:0]         r_be_last;
    logic [3:0]         r_be_first;
    logic [31:0]        r_addr_hi;
    logic [ADDR-3:0]    r_addr;
    logic [9:0]         r_cnt;
    logic               r_rd_h_valid;
    logic               r_wr_h_valid;
    logic               r_err_unsup;
    logic               r_err_malf;

    logic               w_tlp_ready;
    logic               w_wr_d_valid;
    logic               w_wr_d_last;
    logic               w_beat;
    logic               w_cnt_one;
    logic               w_fin;
    logic               w_unsup;
    logic               w_malf;
    logic               w_rd_set;
    logic               w_wr_set;

    assign w_beat    = w_tlp_ready && io_tlp.tlp_valid;
    assign w_cnt_one = (r_cnt == 10'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st <= ST_H0;
        end else begin
            r_st <= w_st_nxt;
        end
    end

    always_comb begin
        w_st_nxt = r_st;
        w_fin    = 1'b0;
        w_unsup  = 1'b0;
        w_malf   = 1'b0;
        w_rd_set = 1'b0;
        w_wr_set = 1'b0;
        if (w_beat) begin
            case (r_st)
                ST_H0: begin
                    if (io_tlp.tlp_data[28:24] != 5'd0) begin
                        w_unsup  = 1'b1;
                        w_st_nxt = io_tlp.tlp_last ? ST_H0 : ST_DROP;
                    end else if (io_tlp.tlp_last) begin
                        w_malf   = 1'b1;
                        w_st_nxt = ST_H0;
                    end else begin
                        w_st_nxt = ST_H1;
                    end
                end
                ST_H1: begin
                    w_malf   = io_tlp.tlp_last;
                    w_st_nxt = io_tlp.tlp_last ? ST_H0 : ST_H2;
                end
                ST_H2: begin
                    if (!r_fmt[0]) begin
                        w_fin = 1'b1;
                    end else if (|(io_tlp.tlp_data & c_HI_MASK)) begin
                        w_unsup  = 1'b1;
                        w_malf   = io_tlp.tlp_last;
                        w_st_nxt = io_tlp.tlp_last ? ST_H0 : ST_DROP;
                    end else begin
                        w_malf   = io_tlp.tlp_last;
                        w_st_nxt = io_tlp.tlp_last ? ST_H0 : ST_H3;
                    end
                end
                ST_H3: begin
                    w_fin = 1'b1;
                end
                ST_DATA: begin
                    if (w_cnt_one) begin
                        // With TD set exactly one ECRC dword must still follow
                        w_malf   = io_tlp.tlp_last ? r_td : !r_td;
                        w_st_nxt = io_tlp.tlp_last ? ST_H0 : ST_DROP;
                    end else if (io_tlp.tlp_last) begin
                        w_malf   = 1'b1;
                        w_st_nxt = ST_H0;
                    end
                end
                ST_DROP: begin
                    if (io_tlp.tlp_last) begin
                        w_st_nxt = ST_H0;
                    end
                end
                default: begin
                    w_st_nxt = ST_H0;
                end
            endcase

            if (w_fin) begin
                if (r_fmt[1]) begin
                    w_malf   = io_tlp.tlp_last;
                    w_wr_set = !io_tlp.tlp_last;
                    w_st_nxt = io_tlp.tlp_last ? ST_H0 : ST_DATA;
                end else if (r_td) begin
                    w_malf   = io_tlp.tlp_last;
                    w_rd_set = !io_tlp.tlp_last;
                    w_st_nxt = io_tlp.tlp_last ? ST_H0 : ST_DROP;
                end else begin
                    w_malf   = !io_tlp.tlp_last;
                    w_rd_set = io_tlp.tlp_last;
                    w_st_nxt = io_tlp.tlp_last ? ST_H0 : ST_DROP;
                end
            end
        end
    end

    always_comb begin
        w_tlp_ready  = 1'b0;
        w_wr_d_valid = 1'b0;
        w_wr_d_last  = 1'b0;
        case (r_st)
            ST_DATA: begin
                w_tlp_ready  = io_tlp.wr_d_ready;
                w_wr_d_valid = io_tlp.tlp_valid;
                w_wr_d_last  = w_cnt_one || io_tlp.tlp_last;
            end
            ST_DROP: begin
                w_tlp_ready  = 1'b1;
            end
            default: begin
                // Single header slot: hold off the next header until accepted
                w_tlp_ready  = !r_rd_h_valid && !r_wr_h_valid;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fmt        <= 2'd0;
            r_tc         <= 3'd0;
            r_td         <= 1'b0;
            r_attr       <= 2'd0;
            r_len        <= 10'd0;
            r_req_id     <= 16'd0;
            r_tag        <= 8'd0;
            r_be_last    <= 4'd0;
            r_be_first   <= 4'd0;
            r_addr_hi    <= 32'd0;
            r_addr       <= '0;
            r_cnt        <= 10'd0;
            r_rd_h_valid <= 1'b0;
            r_wr_h_valid <= 1'b0;
            r_err_unsup  <= 1'b0;
            r_err_malf   <= 1'b0;
        end else begin
            r_err_unsup <= w_unsup;
            r_err_malf  <= w_malf;

            if (w_rd_set) begin
                r_rd_h_valid <= 1'b1;
            end else if (io_tlp.rd_h_ready) begin
                r_rd_h_valid <= 1'b0;
            end

            if (w_wr_set) begin
                r_wr_h_valid <= 1'b1;
            end else if (io_tlp.wr_h_ready) begin
                r_wr_h_valid <= 1'b0;
            end

            // A length of 0 wraps to 1023 on the first beat, giving 1024 beats
            if (w_wr_set) begin
                r_cnt <= r_len;
            end else if (w_beat && (r_st == ST_DATA)) begin
                r_cnt <= r_cnt - 10'd1;
            end

            if (w_beat) begin
                case (r_st)
                    ST_H0: begin
                        r_fmt  <= io_tlp.tlp_data[30:29];
                        r_tc   <= io_tlp.tlp_data[22:20];
                        r_td   <= io_tlp.tlp_data[15];
                        r_attr <= io_tlp.tlp_data[13:12];
                        r_len  <= io_tlp.tlp_data[9:0];
                    end
                    ST_H1: begin
                        r_req_id   <= io_tlp.tlp_data[31:16];
                        r_tag      <= io_tlp.tlp_data[15:8];
                        r_be_last  <= io_tlp.tlp_data[7:4];
                        r_be_first <= io_tlp.tlp_data[3:0];
                    end
                    ST_H2: begin
                        if (r_fmt[0]) begin
                            r_addr_hi <= io_tlp.tlp_data;
                        end else begin
                            r_addr <= (ADDR-2)'({32'h0, io_tlp.tlp_data} >> 2);
                        end
                    end
                    ST_H3: begin
                        r_addr <= (ADDR-2)'({r_addr_hi, io_tlp.tlp_data} >> 2);
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign io_tlp.tlp_ready       = w_tlp_ready;

    assign io_tlp.rd_h_valid      = r_rd_h_valid;
    assign io_tlp.rd_h_addr       = r_addr;
    assign io_tlp.rd_h_len        = r_len;
    assign io_tlp.rd_h_tag        = r_tag;
    assign io_tlp.rd_h_req_id     = r_req_id;
    assign io_tlp.rd_h_tc         = r_tc;
    assign io_tlp.rd_h_attr       = r_attr;
    assign io_tlp.rd_h_be_first   = r_be_first;
    assign io_tlp.rd_h_be_last    = r_be_last;

    assign io_tlp.wr_h_valid      = r_wr_h_valid;
    assign io_tlp.wr_h_addr       = r_addr;
    assign io_tlp.wr_h_len        = r_len;
    assign io_tlp.wr_h_be_first   = r_be_first;
    assign io_tlp.wr_h_be_last    = r_be_last;

    assign io_tlp.wr_d_valid      = w_wr_d_valid;
    assign io_tlp.wr_d_data       = io_tlp.tlp_data;
    assign io_tlp.wr_d_last       = w_wr_d_last;

    assign io_tlp.err_unsupported = r_err_unsup;
    assign io_tlp.err_malformed   = r_err_malf;
endmodule
`default_nettype wire
